addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Two-port round-robin arbiter and sequencer for the single shared 16-bit saturating adder/subtractor (`addsub_16bit`). It lets two requesters take turns on one adder instance, such as the ALU execute path and the branch-target/PC-offset path. Each requester uses a valid/ready handshake. The arbiter registers each result and returns it through a single response slot with backpressure, so a requester never has to wait on the other's combinational path.

## Interface
- `FIRST_PRIO`, default 0: requester that wins the first contended arbitration after reset (0 or 1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle (grant).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  16 each  signed operands.
- `req0_sub`, `req1_sub`  in  1 each  0 = A+B, 1 = A−B.
- `resp_valid`  out  1  result slot full.
- `resp_ready`  in  1  consumer takes the result this cycle.
- `resp_id`  out  1  index of the requester that owns the result.
- `resp_sum`  out  16  saturated result.
- `resp_ovfl`  out  1  signed overflow occurred (result was clamped).

## Operation
- Arithmetic is 16-bit two's complement.
  - Positive overflow clamps to 16'h7FFF; negative overflow clamps to 16'h8000.
  - `resp_ovfl` is 1 exactly when clamping occurred.
  - `sub` = 1 computes A + ~B + 1.
- States:
  - IDLE: slot empty.
  - FULL: slot holds an unconsumed result.
- Slot is free (`can_issue`) when in IDLE, or when in FULL with `resp_ready`=1.
- Grant rule, evaluated only when `can_issue`:
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester other than `last_grant` is granted.
  - At most one `reqN_ready` is high per cycle.
  - `reqN_ready` is never high while `can_issue` is 0.
- On grant:
  - The chosen operands pass through the shared adder.
  - Sum, overflow and id register at the clock edge.
  - `last_grant` updates to the granted index.
  - Next state is FULL.
- FULL with `resp_ready`=1 and no valid request: next state is IDLE.
- FULL with `resp_ready`=0: outputs hold stable and no grant occurs.
- Requester obligations: operands and `sub` stay stable while `valid` is high and `ready` is low. A requester may not drop `valid` before it is granted. The bench asserts this as a protocol check; the design does not check it.
- `last_grant` resets to 1−`FIRST_PRIO`, so `FIRST_PRIO` wins the first tie.

## Timing
- Reset values:
  - `resp_valid` = 0, `resp_id` = 0, `resp_sum` = 16'h0000, `resp_ovfl` = 0.
  - `req0_ready` = `req1_ready` = 0; state IDLE.
- Latency: a grant in cycle N produces `resp_valid` = 1 with the result in cycle N+1.
- Throughput: one result per cycle when `resp_ready` is held high. A back-to-back grant in the consume cycle leaves no bubble.
- `reqN_ready` is combinational from valids, state, `resp_ready` and `last_grant`. All `resp_*` outputs come directly from registers.
- Simultaneous consume and grant: the old result is taken and the new result loads at the same edge.
- Both requesters valid continuously with `resp_ready` = 1: grants strictly alternate 0,1,0,1 (given `FIRST_PRIO` = 0).
- Reset asserted mid-transaction:
  - The slot and any pending result are discarded immediately (asynchronous).
  - No response is produced for that transaction.
  - Arbitration restarts from `FIRST_PRIO`.

## Structure
- Shared package `alu_pkg`:
  - `SAT_POS` = 16'h7FFF and `SAT_NEG` = 16'h8000.
  - Enum `arb_state_t` {IDLE, FULL}.
  - `DATA_W` = 16.
- Sub-module: a single `addsub_16bit` instance, pad input tied 0, fed by a 2:1 operand mux selected by the grant. The grant logic is a small combinational round-robin function inside the block. No second adder is allowed.

## Test plan
- Reset, then `req0` valid with 16'h7FFF + 16'h0001 add, `resp_ready`=1 → next cycle `resp_valid`=1, `resp_id`=0, `resp_sum`=16'h7FFF, `resp_ovfl`=1.
- `req1` valid with 16'h8000 − 16'h0001 sub → `resp_id`=1, `resp_sum`=16'h8000, `resp_ovfl`=1. Then 16'h0005 − 16'h0007 → 16'hFFFE, `resp_ovfl`=0.
- Both valid for 4 cycles with distinct operands, `resp_ready`=1 → grants alternate 0,1,0,1, one response per cycle, each response matching its operands.
- `resp_ready`=0 for 3 cycles while `req0` and `req1` are valid → both readies stay 0 and `resp_*` is stable. Then `resp_ready`=1 → the held result is consumed and the other requester is granted in the same cycle.
- `rst_n` pulsed low asynchronously between clock edges while FULL → `resp_valid` drops immediately. The next tie after reset goes to `FIRST_PRIO`, checked with `FIRST_PRIO`=1 as well.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated 16-bit saturating adder/subtractor:
// data width, clamp constants, slot state encoding and the clamp helper.
package alu_pkg;

   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } arb_state_t;

   // Clamp an 18-bit signed sum to 16 bits; returns {ovfl, result}.
   function automatic logic [DATA_W:0] saturate(input logic [DATA_W+1:0] wide);
      logic [DATA_W:0] res;
      if ((wide[DATA_W+1:DATA_W-1] == 3'b000) || (wide[DATA_W+1:DATA_W-1] == 3'b111)) begin
         res = {1'b0, wide[DATA_W-1:0]};
      end else if (wide[DATA_W+1] == 1'b1) begin
         res = {1'b1, SAT_NEG};
      end else begin
         res = {1'b1, SAT_POS};
      end
      return res;
   endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two requesters plus a consumer and the
// shared adder arbiter.
interface addsub_arbiter_if;
   import alu_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_sub;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_sub;

   logic              resp_valid;
   logic              resp_ready;
   logic              resp_id;
   logic [DATA_W-1:0] resp_sum;
   logic              resp_ovfl;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_sum, resp_ovfl
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_sum, resp_ovfl
   );

endinterface

// File: rtl/addsub_16bit.sv
// 16-bit signed saturating adder/subtractor; pad_i is a spare carry-in that
// the arbiter ties low.
module addsub_16bit
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   input  logic              pad_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              ovfl_o
);

   logic [DATA_W+1:0] a_ext_s;
   logic [DATA_W+1:0] b_ext_s;
   logic [DATA_W+1:0] wide_s;
   logic [DATA_W:0]   sat_s;

   // Two guard bits keep A - B and the extra carry-ins from wrapping.
   assign a_ext_s = {{2{a_i[DATA_W-1]}}, a_i};
   assign b_ext_s = sub_i ? ~{{2{b_i[DATA_W-1]}}, b_i} : {{2{b_i[DATA_W-1]}}, b_i};
   assign wide_s  = a_ext_s + b_ext_s
                  + {{(DATA_W+1){1'b0}}, sub_i}
                  + {{(DATA_W+1){1'b0}}, pad_i};
   assign sat_s   = saturate(wide_s);
   assign sum_o   = sat_s[DATA_W-1:0];
   assign ovfl_o  = sat_s[DATA_W];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one saturating adder between two requesters,
// with a single registered response slot that accepts backpressure.
module addsub_arbiter #(
   parameter int FIRST_PRIO = 0
) (
   input logic              clk,
   input logic              rst_n,
   addsub_arbiter_if.slave  bus
);
   import alu_pkg::*;

   localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

   arb_state_t        state_q;
   logic              last_grant_q;
   logic              resp_id_q;
   logic [DATA_W-1:0] resp_sum_q;
   logic              resp_ovfl_q;

   logic              can_issue_s;
   logic [1:0]        grant_s;
   logic              load_s;
   logic [DATA_W-1:0] op_a_s;
   logic [DATA_W-1:0] op_b_s;
   logic              op_sub_s;
   logic [DATA_W-1:0] sum_d;
   logic              ovfl_d;

   // One-hot grant; on a tie the requester that did not win last time goes.
   function automatic logic [1:0] rr_grant(input logic en, input logic v0,
                                           input logic v1, input logic last);
      logic [1:0] g;
      g = 2'b00;
      if (!en) begin
         g = 2'b00;
      end else if (v0 && v1) begin
         g = last ? 2'b01 : 2'b10;
      end else begin
         g = {v1, v0};
      end
      return g;
   endfunction

   assign can_issue_s = (state_q == IDLE) || bus.resp_ready;
   assign grant_s     = rr_grant(can_issue_s, bus.req0_valid, bus.req1_valid, last_grant_q);
   assign load_s      = grant_s[0] | grant_s[1];

   // Operand mux in front of the shared adder, steered by the grant.
   always_comb begin
      op_a_s   = bus.req0_a;
      op_b_s   = bus.req0_b;
      op_sub_s = bus.req0_sub;
      if (grant_s[1]) begin
         op_a_s   = bus.req1_a;
         op_b_s   = bus.req1_b;
         op_sub_s = bus.req1_sub;
      end else begin
         op_a_s   = bus.req0_a;
         op_b_s   = bus.req0_b;
         op_sub_s = bus.req0_sub;
      end
   end

   addsub_16bit u_addsub (
      .a_i    (op_a_s),
      .b_i    (op_b_s),
      .sub_i  (op_sub_s),
      .pad_i  (1'b0),
      .sum_o  (sum_d),
      .ovfl_o (ovfl_d)
   );

   // Response slot FSM: a grant loads the slot even while the old result is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_RST;
         resp_id_q    <= 1'b0;
         resp_sum_q   <= {DATA_W{1'b0}};
         resp_ovfl_q  <= 1'b0;
      end else begin
         if (load_s) begin
            resp_id_q    <= grant_s[1];
            resp_sum_q   <= sum_d;
            resp_ovfl_q  <= ovfl_d;
            last_grant_q <= grant_s[1];
         end else begin
            last_grant_q <= last_grant_q;
         end
         case (state_q)
            IDLE: begin
               state_q <= load_s ? FULL : IDLE;
            end
            FULL: begin
               if (load_s) begin
                  state_q <= FULL;
               end else if (bus.resp_ready) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= FULL;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready = grant_s[0];
   assign bus.req1_ready = grant_s[1];
   assign bus.resp_valid = (state_q == FULL);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_sum   = resp_sum_q;
   assign bus.resp_ovfl  = resp_ovfl_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: vector table, directed corner
// sequences and a randomized phase against an arithmetic reference model.
module tb_addsub_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   addsub_arbiter_if bus0 ();
   addsub_arbiter_if bus1 ();

   addsub_arbiter #(.FIRST_PRIO(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   addsub_arbiter #(.FIRST_PRIO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int total = 0;
   int bad   = 0;

   bit          m_full;
   bit          m_id;
   bit          m_ovfl;
   bit          m_last;
   logic [15:0] m_sum;
   bit          g0;
   bit          g1;

   typedef struct {
      bit          id;
      logic [15:0] a;
      logic [15:0] b;
      bit          sub;
      logic [15:0] exp_sum;
      bit          exp_ovfl;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic ref_calc(input logic [15:0] a, input logic [15:0] b, input bit sub,
                           output logic [15:0] r, output bit ov);
      int sa;
      int sb;
      int x;
      sa = $signed(a);
      sb = $signed(b);
      x  = sub ? (sa - sb) : (sa + sb);
      if (x > 32767) begin
         r = 16'h7FFF; ov = 1'b1;
      end else if (x < -32768) begin
         r = 16'h8000; ov = 1'b1;
      end else begin
         r = x[15:0]; ov = 1'b0;
      end
   endtask

   task automatic model_grant(output bit o0, output bit o1);
      bit can;
      can = !m_full || (bus0.resp_ready === 1'b1);
      o0  = can && (bus0.req0_valid === 1'b1) && ((bus0.req1_valid !== 1'b1) || m_last);
      o1  = can && (bus0.req1_valid === 1'b1) && ((bus0.req0_valid !== 1'b1) || !m_last);
   endtask

   task automatic model_step(input bit o0, input bit o1);
      if (o0 || o1) begin
         if (o1) ref_calc(bus0.req1_a, bus0.req1_b, bus0.req1_sub, m_sum, m_ovfl);
         else    ref_calc(bus0.req0_a, bus0.req0_b, bus0.req0_sub, m_sum, m_ovfl);
         m_id   = o1;
         m_last = o1;
         m_full = 1'b1;
      end else if (m_full && bus0.resp_ready) begin
         m_full = 1'b0;
      end
   endtask

   task automatic check_resp();
      chk("resp_valid", bus0.resp_valid, m_full);
      if (m_full) begin
         chk("resp_id", bus0.resp_id, m_id);
         chk("resp_sum", bus0.resp_sum, m_sum);
         chk("resp_ovfl", bus0.resp_ovfl, m_ovfl);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_grant(g0, g1);
      chk("req0_ready", bus0.req0_ready, g0);
      chk("req1_ready", bus0.req1_ready, g1);
      @(posedge clk);
      model_step(g0, g1);
      #1;
      check_resp();
   endtask

   task automatic set_req(input int id, input bit v, input logic [15:0] a,
                          input logic [15:0] b, input bit sub);
      if (id == 0) begin
         bus0.req0_valid = v; bus0.req0_a = a; bus0.req0_b = b; bus0.req0_sub = sub;
      end else begin
         bus0.req1_valid = v; bus0.req1_a = a; bus0.req1_b = b; bus0.req1_sub = sub;
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      m_full = 1'b0;
      m_last = 1'b1;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd16();
      logic [15:0] v;
      case ($urandom_range(0, 4))
         0:       v = 16'h7FFF;
         1:       v = 16'h8000;
         2:       v = 16'hFFFF;
         default: v = 16'($urandom());
      endcase
      return v;
   endfunction

   // Requesters must hold valid and operands until granted.
   logic        pend0_q, pend1_q;
   logic [32:0] snap0_q, snap1_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
      end else begin
         if (pend0_q) assert (bus0.req0_valid && ({bus0.req0_a, bus0.req0_b, bus0.req0_sub} == snap0_q))
            else $error("protocol: req0 changed while waiting");
         if (pend1_q) assert (bus0.req1_valid && ({bus0.req1_a, bus0.req1_b, bus0.req1_sub} == snap1_q))
            else $error("protocol: req1 changed while waiting");
         pend0_q <= bus0.req0_valid && !bus0.req0_ready;
         pend1_q <= bus0.req1_valid && !bus0.req1_ready;
         snap0_q <= {bus0.req0_a, bus0.req0_b, bus0.req0_sub};
         snap1_q <= {bus0.req1_a, bus0.req1_b, bus0.req1_sub};
      end
   end

   logic [17:0] held;

   initial begin
      vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1};
      vecs[1] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1};
      vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
      vecs[3] = '{1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
      vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1};
      vecs[5] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
      vecs[6] = '{1'b0, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
      vecs[7] = '{1'b1, 16'hFFFF, 16'h7FFF, 1'b1, 16'h8000, 1'b0};
      vecs[8] = '{1'b0, 16'h7FFE, 16'h0001, 1'b0, 16'h7FFF, 1'b0};

      rst_n = 1'b0;
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      bus0.resp_ready = 1'b0;
      bus1.req0_valid = 1'b0; bus1.req0_a = 16'h0001; bus1.req0_b = 16'h0002; bus1.req0_sub = 1'b0;
      bus1.req1_valid = 1'b0; bus1.req1_a = 16'h7FFF; bus1.req1_b = 16'h8000; bus1.req1_sub = 1'b1;
      bus1.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus0.resp_valid, 1'b0);
      chk("rst_id", bus0.resp_id, 1'b0);
      chk("rst_sum", bus0.resp_sum, 16'h0000);
      chk("rst_ovfl", bus0.resp_ovfl, 1'b0);
      chk("rst_ready", {bus0.req0_ready, bus0.req1_ready}, 2'b00);
      chk("rst_valid_p1", bus1.resp_valid, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      m_full = 1'b0;
      m_last = 1'b1;
      @(posedge clk);
      #1;

      // Vector table, one transaction per cycle with the consumer always ready.
      bus0.resp_ready = 1'b1;
      foreach (vecs[i]) begin
         set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
         set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
         set_req(int'(vecs[i].id), 1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
         tick();
         chk("vec_valid", bus0.resp_valid, 1'b1);
         chk("vec_id", bus0.resp_id, vecs[i].id);
         chk("vec_sum", bus0.resp_sum, vecs[i].exp_sum);
         chk("vec_ovfl", bus0.resp_ovfl, vecs[i].exp_ovfl);
      end
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Continuous tie: grants alternate starting from requester 0.
      reset_pulse();
      bus0.resp_ready = 1'b1;
      set_req(0, 1'b1, 16'h0100, 16'h0001, 1'b0);
      set_req(1, 1'b1, 16'h0200, 16'h0002, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("alt_valid", bus0.resp_valid, 1'b1);
         chk("alt_id", bus0.resp_id, i % 2);
         if (i % 2 == 0) set_req(0, 1'b1, 16'h0110 + 16'(i), 16'h0003, 1'b0);
         else            set_req(1, 1'b1, 16'h0220 + 16'(i), 16'h0004, 1'b1);
      end

      // Backpressure: slot holds, no grants, then consume-and-regrant.
      bus0.resp_ready = 1'b0;
      held = {bus0.resp_id, bus0.resp_ovfl, bus0.resp_sum};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_ready", {bus0.req0_ready, bus0.req1_ready}, 2'b00);
         chk("bp_hold", {bus0.resp_id, bus0.resp_ovfl, bus0.resp_sum}, held);
         chk("bp_valid", bus0.resp_valid, 1'b1);
      end
      bus0.resp_ready = 1'b1;
      tick();
      chk("bp_regrant_valid", bus0.resp_valid, 1'b1);
      chk("bp_regrant_id", bus0.resp_id, 1'b0);

      // Asynchronous reset while the slot is full.
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      bus0.resp_ready = 1'b0;
      tick();
      chk("pre_rst_valid", bus0.resp_valid, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus0.resp_valid, 1'b0);
      m_full = 1'b0;
      m_last = 1'b1;
      set_req(0, 1'b1, 16'h4000, 16'h4000, 1'b0);
      bus0.resp_ready = 1'b1;
      bus1.req0_valid = 1'b1;
      bus1.req1_valid = 1'b1;
      bus1.resp_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("tie_p0_ready", {bus0.req1_ready, bus0.req0_ready}, 2'b01);
      chk("tie_p1_ready", {bus1.req1_ready, bus1.req0_ready}, 2'b10);
      @(posedge clk);
      model_grant(g0, g1);
      model_step(g0, g1);
      #1;
      check_resp();
      chk("tie_p0_id", bus0.resp_id, 1'b0);
      chk("tie_p0_sum", bus0.resp_sum, 16'h7FFF);
      chk("tie_p1_valid", bus1.resp_valid, 1'b1);
      chk("tie_p1_id", bus1.resp_id, 1'b1);
      chk("tie_p1_sum", bus1.resp_sum, 16'h7FFF);
      chk("tie_p1_ovfl", bus1.resp_ovfl, 1'b1);
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      tick();
      chk("p1_next_id", bus1.resp_id, 1'b0);
      chk("p1_next_sum", bus1.resp_sum, 16'h0003);
      chk("p1_next_ovfl", bus1.resp_ovfl, 1'b0);

      // Randomized traffic and backpressure against the reference model.
      for (int c = 0; c < 400; c++) begin
         bus0.resp_ready = ($urandom_range(0, 3) != 0);
         if (!(bus0.req0_valid && !g0))
            set_req(0, $urandom_range(0, 2) != 0, rnd16(), rnd16(), 1'($urandom_range(0, 1)));
         if (!(bus0.req1_valid && !g1))
            set_req(1, $urandom_range(0, 2) != 0, rnd16(), rnd16(), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
